// File: rtl/npc_mem_pkg.sv
// rtl/npc_mem_pkg.sv - shared types, memory window constants and pmem access functions
package npc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } npc_mem_state_e;

  localparam logic [31:0] NPC_MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] NPC_MEM_SIZE = 32'h0800_0000;
  localparam int          WMASK_W      = 4;

  // Call counters let a bench confirm which accesses actually reached memory.
  int unsigned pmem_reads;
  int unsigned pmem_writes;
  bit [31:0]   pmem_words [bit [29:0]];

  function automatic int npc_pmem_read(input int raddr);
    bit [29:0] idx;
    idx = raddr[31:2];
    pmem_reads++;
    if (pmem_words.exists(idx)) begin
      return pmem_words[idx];
    end
    return 0;
  endfunction

  function automatic void npc_pmem_write(input int waddr, input int wdata, input byte wmask);
    bit [29:0] idx;
    bit [31:0] cur;
    idx = waddr[31:2];
    cur = pmem_words.exists(idx) ? pmem_words[idx] : 32'h0;
    pmem_writes++;
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) begin
        cur[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    pmem_words[idx] = cur;
  endfunction

endpackage

// File: rtl/npc_mem_if.sv
// rtl/npc_mem_if.sv - LSU to memory responder request and response channels
interface npc_mem_if;
  import npc_mem_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_wen;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [WMASK_W-1:0] req_wmask;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/npc_mem_lfsr.sv
// rtl/npc_mem_lfsr.sv - 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) for latency jitter
module npc_mem_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic       feedback;

  assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign value    = lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[6:0], feedback};
    end
  end

endmodule

// File: rtl/npc_mem_responder.sv
// rtl/npc_mem_responder.sv - single-outstanding latency-bearing pmem responder
// NPC_MEM_RANDOM_DELAY_EN adds LFSR-driven extra latency of 0..3 cycles.
module npc_mem_responder
  import npc_mem_pkg::*;
#(
  parameter int          LAT      = 2,
  parameter logic [31:0] MEM_BASE = NPC_MEM_BASE,
  parameter logic [31:0] MEM_SIZE = NPC_MEM_SIZE
) (
  input  logic     clk,
  input  logic     reset,
  npc_mem_if.slave bus
);

  localparam int CNT_W = $clog2(LAT + 4) + 1;

  if (LAT < 1) begin : g_bad_lat
    $error("npc_mem_responder: LAT must be at least 1");
  end

  npc_mem_state_e     state_q;
  npc_mem_state_e     state_d;
  logic               req_ready_c;
  logic               accept;
  logic               commit;
  logic               rsp_fire;
  logic               in_range;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_load;
  logic               wen_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [WMASK_W-1:0] wmask_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic               rsp_valid_q;

`ifdef NPC_MEM_RANDOM_DELAY_EN
  logic [7:0] lfsr;

  npc_mem_lfsr #(.SEED(8'hA5)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .value   (lfsr)
  );

  // Uses the pre-advance value: the LFSR steps on the same edge as the load.
  assign cnt_load = CNT_W'(LAT - 1) + {{(CNT_W-2){1'b0}}, lfsr[1:0]};
`else
  assign cnt_load = CNT_W'(LAT - 1);
`endif

  assign accept   = req_ready_c && bus.req_valid;
  assign commit   = (state_q == ST_BUSY) && (cnt_q == '0);
  assign rsp_fire = (state_q == ST_RESP) && bus.rsp_ready;
  assign in_range = (addr_q >= MEM_BASE) && ((addr_q - MEM_BASE) < MEM_SIZE);

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory side effects happen only at commit, so a reset in BUSY drops the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= bus.req_wen;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        wmask_q <= bus.req_wmask;
        cnt_q   <= cnt_load;
      end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (commit) begin
        rsp_valid_q <= 1'b1;
        if (!in_range) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (wen_q) begin
          npc_pmem_write(addr_q, wdata_q, {4'b0000, wmask_q});
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else begin
          rdata_q <= npc_pmem_read(addr_q);
          err_q   <= 1'b0;
        end
      end else if (rsp_fire) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_npc_mem_responder.sv
// tb/tb_npc_mem_responder.sv - directed bench for npc_mem_responder (LAT=2 and LAT=4 instances)
module tb_npc_mem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 4;

  logic       clk;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] lfsr_a = 8'hA5;

  npc_mem_if if_a ();
  npc_mem_if if_b ();

  npc_mem_responder #(.LAT(LAT_A)) u_a (.clk(clk), .reset(rst_a), .bus(if_a));
  npc_mem_responder #(.LAT(LAT_B)) u_b (.clk(clk), .reset(rst_b), .bus(if_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic next_lat_a(output int e);
`ifdef NPC_MEM_RANDOM_DELAY_EN
    e      = LAT_A + int'(lfsr_a[1:0]);
    lfsr_a = lfsr_step(lfsr_a);
`else
    e = LAT_A;
`endif
  endtask

  // Drives one transaction on instance A starting from IDLE; returns after the handshake edge.
  task automatic txn_a(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, output int lat, output int exp_lat,
                       output logic [31:0] rdata, output logic err, output int acc_cyc);
    next_lat_a(exp_lat);
    if_a.req_valid = 1'b1;
    if_a.req_wen   = wen;
    if_a.req_addr  = addr;
    if_a.req_wdata = wdata;
    if_a.req_wmask = wmask;
    if_a.rsp_ready = 1'b1;
    @(posedge clk); #1;
    acc_cyc        = cyc;
    if_a.req_valid = 1'b0;
    if_a.req_wen   = ~wen;
    if_a.req_addr  = ~addr;
    if_a.req_wdata = ~wdata;
    if_a.req_wmask = ~wmask;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (if_a.rsp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    rdata = if_a.rsp_rdata;
    err   = if_a.rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    checks++; if (if_a.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", if_a.req_ready); end
    checks++; if (if_a.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", if_a.rsp_valid); end
    checks++; if (if_a.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", if_a.rsp_rdata); end
    checks++; if (if_a.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", if_a.rsp_err); end
    checks++; if (if_b.req_ready !== 1'b1) begin errors++; $display("FAIL reset_b_req_ready: got %b expected 1", if_b.req_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    lfsr_a = 8'hA5;
    @(posedge clk); #1;
    checks++; if ({if_a.req_ready, if_a.rsp_valid} !== 2'b10) begin errors++; $display("FAIL post_reset_idle: got %b expected 10", {if_a.req_ready, if_a.rsp_valid}); end
  endtask

  task automatic test_read_latency;
    int lat, e, acc;
    logic [31:0] rd;
    logic er;
    int unsigned w0, r0;
    w0 = npc_mem_pkg::pmem_writes;
    r0 = npc_mem_pkg::pmem_reads;
    txn_a(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, e, rd, er, acc);
    checks++; if (lat != e) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, e); end
    checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL wr_rsp: got err=%b rdata=%h expected 0/0", er, rd); end
    txn_a(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, e, rd, er, acc);
    checks++; if (lat != e) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, e); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", er); end
    checks++; if (npc_mem_pkg::pmem_writes != w0 + 1) begin errors++; $display("FAIL wr_calls: got %0d expected %0d", npc_mem_pkg::pmem_writes, w0 + 1); end
    checks++; if (npc_mem_pkg::pmem_reads != r0 + 1) begin errors++; $display("FAIL rd_calls: got %0d expected %0d", npc_mem_pkg::pmem_reads, r0 + 1); end
  endtask

  task automatic test_masked_write;
    int lat, e, acc;
    logic [31:0] rd;
    logic er;
    txn_a(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'hF, lat, e, rd, er, acc);
    txn_a(1'b1, 32'h8000_0020, 32'h1122_3344, 4'b0011, lat, e, rd, er, acc);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL mask_wr_err: got %b expected 0", er); end
    txn_a(1'b0, 32'h8000_0020, 32'h0, 4'h0, lat, e, rd, er, acc);
    checks++; if (rd !== 32'hAABB_3344) begin errors++; $display("FAIL mask_readback: got %h expected aabb3344", rd); end
  endtask

  task automatic test_zero_mask;
    int lat, e, acc;
    logic [31:0] rd;
    logic er;
    int unsigned w0;
    w0 = npc_mem_pkg::pmem_writes;
    txn_a(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, lat, e, rd, er, acc);
    checks++; if ({er, rd} !== 33'h0 || lat != e) begin errors++; $display("FAIL zmask_rsp: got err=%b rdata=%h lat=%0d expected 0/0/%0d", er, rd, lat, e); end
    checks++; if (npc_mem_pkg::pmem_writes != w0 + 1) begin errors++; $display("FAIL zmask_calls: got %0d expected %0d", npc_mem_pkg::pmem_writes, w0 + 1); end
    txn_a(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, e, rd, er, acc);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zmask_readback: got %h expected deadbeef", rd); end
  endtask

  task automatic test_out_of_range;
    int lat, e, acc;
    logic [31:0] rd;
    logic er;
    int unsigned w0, r0;
    w0 = npc_mem_pkg::pmem_writes;
    r0 = npc_mem_pkg::pmem_reads;
    txn_a(1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, lat, e, rd, er, acc);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL oor_below: got err=%b rdata=%h expected 1/0", er, rd); end
    checks++; if (npc_mem_pkg::pmem_writes != w0) begin errors++; $display("FAIL oor_wr_calls: got %0d expected %0d", npc_mem_pkg::pmem_writes, w0); end
    txn_a(1'b0, 32'h8800_0000, 32'h0, 4'h0, lat, e, rd, er, acc);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL oor_top: got err=%b rdata=%h expected 1/0", er, rd); end
    checks++; if (npc_mem_pkg::pmem_reads != r0) begin errors++; $display("FAIL oor_rd_calls: got %0d expected %0d", npc_mem_pkg::pmem_reads, r0); end
    txn_a(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, lat, e, rd, er, acc);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_max: got err=%b expected 1", er); end
    txn_a(1'b1, 32'h87FF_FFFC, 32'h5A5A_0F0F, 4'hF, lat, e, rd, er, acc);
    txn_a(1'b0, 32'h87FF_FFFC, 32'h0, 4'h0, lat, e, rd, er, acc);
    checks++; if ({er, rd} !== {1'b0, 32'h5A5A_0F0F}) begin errors++; $display("FAIL last_word: got err=%b rdata=%h expected 0/5a5a0f0f", er, rd); end
  endtask

  task automatic test_backpressure;
    int e, lat;
    next_lat_a(e);
    if_a.req_valid = 1'b1;
    if_a.req_wen   = 1'b0;
    if_a.req_addr  = 32'h8000_0020;
    if_a.rsp_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (if_a.req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: req_ready got %b expected 0", if_a.req_ready); end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (if_a.rsp_valid === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != e) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, e); end
    if_a.req_addr = 32'h8000_0010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({if_a.rsp_valid, if_a.req_ready, if_a.rsp_err, if_a.rsp_rdata} !== {3'b100, 32'hAABB_3344}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b err=%b rdata=%h expected 1/0/0/aabb3344", i, if_a.rsp_valid, if_a.req_ready, if_a.rsp_err, if_a.rsp_rdata);
      end
    end
    if_a.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({if_a.rsp_valid, if_a.req_ready} !== 2'b01) begin errors++; $display("FAIL bp_handshake: got v/rdy=%b expected 01", {if_a.rsp_valid, if_a.req_ready}); end
    next_lat_a(e);
    @(posedge clk); #1;
    checks++; if (if_a.req_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: req_ready got %b expected 0", if_a.req_ready); end
    if_a.req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (if_a.rsp_valid === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat != e || if_a.rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_second: got lat=%0d rdata=%h expected %0d/deadbeef", lat, if_a.rsp_rdata, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3] = '{32'h8000_0010, 32'h8000_0020, 32'h87FF_FFFC};
    logic [31:0] datas [3] = '{32'hDEAD_BEEF, 32'hAABB_3344, 32'h5A5A_0F0F};
    int lat, e, acc, prev_acc, prev_e;
    logic [31:0] rd;
    logic er;
    prev_acc = 0;
    prev_e   = 0;
    for (int k = 0; k < 8; k++) begin
      txn_a(1'b0, addrs[k % 3], 32'h0, 4'h0, lat, e, rd, er, acc);
      checks++; if (lat != e || lat < 2 || lat > 5) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", k, lat, e); end
      checks++; if (rd !== datas[k % 3]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, rd, datas[k % 3]); end
      if (k > 0) begin
        checks++; if (acc - prev_acc != prev_e + 2) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", k, acc - prev_acc, prev_e + 2); end
      end
      prev_acc = acc;
      prev_e   = e;
    end
  endtask

  task automatic test_reset_mid_write;
    int lat, e, acc;
    logic [31:0] rd;
    logic er;
    bit seen;
    int unsigned w0;
    txn_a(1'b1, 32'h8000_0040, 32'h0102_0304, 4'hF, lat, e, rd, er, acc);
    w0 = npc_mem_pkg::pmem_writes;
    if_b.req_valid = 1'b1;
    if_b.req_wen   = 1'b1;
    if_b.req_addr  = 32'h8000_0040;
    if_b.req_wdata = 32'hFFFF_FFFF;
    if_b.req_wmask = 4'hF;
    if_b.rsp_ready = 1'b1;
    @(posedge clk); #1;
    if_b.req_valid = 1'b0;
    checks++; if (if_b.req_ready !== 1'b0) begin errors++; $display("FAIL rmw_accept: req_ready got %b expected 0", if_b.req_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    checks++;
    if ({if_b.req_ready, if_b.rsp_valid, if_b.rsp_err, if_b.rsp_rdata} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL rmw_reset_vals: got rdy=%b v=%b err=%b rdata=%h expected 1/0/0/0", if_b.req_ready, if_b.rsp_valid, if_b.rsp_err, if_b.rsp_rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (if_b.rsp_valid !== 1'b0 || if_b.req_ready !== 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rmw_after_release: got activity expected idle"); end
    checks++; if (npc_mem_pkg::pmem_writes != w0) begin errors++; $display("FAIL rmw_wr_calls: got %0d expected %0d", npc_mem_pkg::pmem_writes, w0); end
    txn_a(1'b0, 32'h8000_0040, 32'h0, 4'h0, lat, e, rd, er, acc);
    checks++; if (rd !== 32'h0102_0304) begin errors++; $display("FAIL rmw_mem: got %h expected 01020304", rd); end
  endtask

  task automatic test_reset_in_resp;
    bit seen;
    if_b.req_valid = 1'b1;
    if_b.req_wen   = 1'b0;
    if_b.req_addr  = 32'h8000_0040;
    if_b.rsp_ready = 1'b0;
    @(posedge clk); #1;
    if_b.req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (if_b.rsp_valid === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen || if_b.rsp_rdata !== 32'h0102_0304) begin errors++; $display("FAIL resp_b_data: got v=%b rdata=%h expected 1/01020304", seen, if_b.rsp_rdata); end
    rst_b = 1'b0;
    #1;
    checks++; if ({if_b.rsp_valid, if_b.rsp_rdata} !== 33'h0) begin errors++; $display("FAIL resp_reset: got v=%b rdata=%h expected 0/0", if_b.rsp_valid, if_b.rsp_rdata); end
    @(posedge clk); #1;
    rst_b = 1'b1;
    if_b.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({if_b.req_ready, if_b.rsp_valid} !== 2'b10) begin errors++; $display("FAIL resp_release: got rdy/v=%b expected 10", {if_b.req_ready, if_b.rsp_valid}); end
  endtask

  initial begin
    if_a.req_valid = 1'b0; if_a.req_wen = 1'b0; if_a.req_addr = '0;
    if_a.req_wdata = '0;   if_a.req_wmask = '0; if_a.rsp_ready = 1'b1;
    if_b.req_valid = 1'b0; if_b.req_wen = 1'b0; if_b.req_addr = '0;
    if_b.req_wdata = '0;   if_b.req_wmask = '0; if_b.rsp_ready = 1'b1;
    test_reset;
    test_read_latency;
    test_masked_write;
    test_zero_mask;
    test_out_of_range;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_write;
    test_reset_in_resp;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
